// File: rtl/self_draw.sv
// Player-ship pixel sweep: latches a command, then writes the ship box and the fire-beam column one pixel per clock.
// Optional build macro SELF_DRAW_TRIANGLE_EN masks the ship box down to a triangle with its apex on the top row.
module self_draw #(
  parameter int unsigned SHIP_W      = 9,
  parameter int unsigned SHIP_H      = 5,
  parameter int unsigned SHIP_Y      = 110,
  parameter int unsigned BEAM_TOP    = 10,
  parameter logic [2:0]  SHIP_COLOUR = 3'b010,
  parameter logic [2:0]  BEAM_COLOUR = 3'b100,
  parameter int unsigned SCREEN_W    = 160
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       self_enable,
  input  logic [1:0] op,
  input  logic [7:0] x,
  output logic       plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BEAM_LEN = SHIP_Y - BEAM_TOP;
  localparam int unsigned CW       = (SHIP_W > 1) ? $clog2(SHIP_W) : 1;
  localparam int unsigned RW       = (SHIP_H > 1) ? $clog2(SHIP_H) : 1;
  localparam int unsigned BW       = (BEAM_LEN > 1) ? $clog2(BEAM_LEN) : 1;
  localparam int unsigned MID      = (SHIP_W - 1) / 2;

  localparam logic [1:0] OP_DRAW  = 2'b00;
  localparam logic [1:0] OP_ERASE = 2'b01;
  localparam logic [1:0] OP_FIRE  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic [2:0] {IDLE, SHIP, BEAM, DONE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [1:0]    op_l, op_l_d;
  logic [7:0]    x_l, x_l_d;

  logic       plot_d, busy_d, done_d;
  logic [7:0] vga_x_d;
  logic [6:0] vga_y_d;
  logic [2:0] colour_d;
  logic [8:0] sum_d;
`ifdef SELF_DRAW_TRIANGLE_EN
  int         tri_dist;
`endif

  // State, counters, command latches and registered pixel outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      bcnt_q  <= '0;
      op_l    <= '0;
      x_l     <= '0;
      plot    <= 1'b0;
      vga_x   <= '0;
      vga_y   <= '0;
      colour  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      bcnt_q  <= bcnt_d;
      op_l    <= op_l_d;
      x_l     <= x_l_d;
      plot    <= plot_d;
      vga_x   <= vga_x_d;
      vga_y   <= vga_y_d;
      colour  <= colour_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next state / counters; outputs are derived from the next-cycle pixel so they land registered on time
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    bcnt_d   = bcnt_q;
    op_l_d   = op_l;
    x_l_d    = x_l;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    vga_x_d  = vga_x;
    vga_y_d  = vga_y;
    colour_d = colour;
    sum_d    = '0;
`ifdef SELF_DRAW_TRIANGLE_EN
    tri_dist = 0;
`endif

    unique case (state_q)
      IDLE: begin
        if (self_enable) begin
          op_l_d  = op;
          x_l_d   = x;
          col_d   = '0;
          row_d   = '0;
          bcnt_d  = '0;
          state_d = (op == OP_NOP) ? DONE : SHIP;
        end
      end
      SHIP: begin
        if (col_q == CW'(SHIP_W - 1)) begin
          col_d = '0;
          if (row_q == RW'(SHIP_H - 1)) begin
            bcnt_d  = '0;
            state_d = BEAM;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      BEAM: begin
        if (bcnt_q == BW'(BEAM_LEN - 1)) state_d = DONE;
        else                             bcnt_d  = bcnt_q + BW'(1);
      end
      DONE: state_d = HOLD;
      HOLD: begin
        // Re-arm only on a new or withdrawn command: one redraw per distinct command
        if (!self_enable || (op != op_l) || (x != x_l)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      SHIP: begin
        sum_d    = {1'b0, x_l_d} + 9'(col_d);
        vga_x_d  = sum_d[7:0];
        vga_y_d  = 7'(SHIP_Y) + 7'(row_d);
        colour_d = (op_l_d == OP_ERASE) ? 3'b000 : SHIP_COLOUR;
        plot_d   = (sum_d < 9'(SCREEN_W));
`ifdef SELF_DRAW_TRIANGLE_EN
        tri_dist = (int'(col_d) >= int'(MID)) ? int'(col_d) - int'(MID) : int'(MID) - int'(col_d);
        plot_d   = plot_d && (tri_dist <= int'(row_d));
`endif
        busy_d   = 1'b1;
      end
      BEAM: begin
        sum_d    = {1'b0, x_l_d} + 9'(MID);
        vga_x_d  = sum_d[7:0];
        vga_y_d  = 7'(SHIP_Y - 1) - 7'(bcnt_d);
        // Non-fire commands repaint the column black so a stale beam never survives
        colour_d = (op_l_d == OP_FIRE) ? BEAM_COLOUR : 3'b000;
        plot_d   = (sum_d < 9'(SCREEN_W));
        busy_d   = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase

    if (op_l_d == OP_DRAW) begin
      colour_d = colour_d;
    end
  end

endmodule

// File: tb/tb_self_draw.sv
// Randomised bench for self_draw: each command is checked pixel by pixel against a list built from the drawing rules.
module tb_self_draw;

  logic       clk = 1'b0;
  logic       reset;
  logic       self_enable;
  logic [1:0] op;
  logic [7:0] x;
  logic       plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       busy;
  logic       done;

  self_draw dut (
    .clk        (clk),
    .reset      (reset),
    .self_enable(self_enable),
    .op         (op),
    .x          (x),
    .plot       (plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .colour     (colour),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected per-cycle pixel stream for the current command
  int e_plot[$];
  int e_x[$];
  int e_y[$];
  int e_col[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic build_model(input int o, input int xv);
    int xx;
    int p;
    int d;
    e_plot.delete(); e_x.delete(); e_y.delete(); e_col.delete();
    if (o == 3) return;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 9; c++) begin
        xx = xv + c;
        p  = (xx < 160) ? 1 : 0;
`ifdef SELF_DRAW_TRIANGLE_EN
        d = (c > 4) ? c - 4 : 4 - c;
        if (d > r) p = 0;
`endif
        e_plot.push_back(p);
        e_x.push_back(xx % 256);
        e_y.push_back(110 + r);
        e_col.push_back((o == 1) ? 0 : 2);
      end
    end
    for (int y = 109; y >= 10; y--) begin
      xx = xv + 4;
      e_plot.push_back((xx < 160) ? 1 : 0);
      e_x.push_back(xx % 256);
      e_y.push_back(y);
      e_col.push_back((o == 2) ? 4 : 0);
    end
  endtask

  // Issue a command from IDLE and follow the whole sweep through the done pulse
  task automatic run_cmd(input logic [1:0] o, input logic [7:0] xv);
    int npix;
    int exp_plots;
    int got_plots;
    build_model(int'(o), int'(xv));
    npix = e_plot.size();
    exp_plots = 0;
    foreach (e_plot[i]) exp_plots += e_plot[i];
    got_plots = 0;
    @(negedge clk);
    self_enable = 1'b1;
    op = o;
    x  = xv;
    @(posedge clk);
    for (int k = 1; k <= npix + 1; k++) begin
      @(negedge clk);
      if (plot === 1'b1) got_plots++;
      if (k <= npix) begin
        check("plot", plot, e_plot[k-1]);
        check("vga_x", vga_x, e_x[k-1]);
        check("vga_y", vga_y, e_y[k-1]);
        check("colour", colour, e_col[k-1]);
        check("busy", busy, 1);
        check("done_early", done, 0);
      end else begin
        check("done", done, 1);
        check("plot_at_done", plot, 0);
        check("busy_at_done", busy, 0);
      end
    end
    check("plot_count", got_plots, exp_plots);
  endtask

  // Command still held after done: nothing more may be drawn
  task automatic hold_quiet(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check("hold_plot", plot, 0);
      check("hold_done", done, 0);
      check("hold_busy", busy, 0);
    end
  endtask

  task automatic release_cmd();
    @(negedge clk);
    self_enable = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1;
    self_enable = 1'b0;
    op = 2'b00;
    x  = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vga_x", vga_x, 0);
    check("rst_vga_y", vga_y, 0);
    check("rst_colour", colour, 0);
    reset = 1'b0;

    run_cmd(2'b00, 8'd82);
    hold_quiet(4);
    release_cmd();

    run_cmd(2'b10, 8'd82);
    hold_quiet(10);
    // Moving the ship re-arms HOLD -> IDLE, then the new command is accepted
    @(negedge clk);
    x = 8'd92;
    @(posedge clk);
    run_cmd(2'b10, 8'd92);
    hold_quiet(3);
    release_cmd();

    run_cmd(2'b00, 8'd155);
    release_cmd();

    // Reset in the middle of a sweep
    @(negedge clk);
    self_enable = 1'b1;
    op = 2'b10;
    x  = 8'd50;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    self_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_plot", plot, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    reset = 1'b0;
    hold_quiet(5);

    run_cmd(2'b11, 8'd30);
    hold_quiet(3);
    release_cmd();

    for (int t = 0; t < 14; t++) begin
      run_cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      hold_quiet(2);
      release_cmd();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
